// File: rtl/mul_dispatch_pkg.sv
// Shared widths and MUL/DIV funct3 encodings for the multiply/divide dispatch wrapper.
package mul_dispatch_pkg;
    localparam int XLEN       = 32;
    localparam int RLEN       = 5;
    localparam int MULBUF_LEN = 2;
    localparam int FUNCT3_W   = 3;

    localparam logic [FUNCT3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [FUNCT3_W-1:0] F3_DIV    = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_REM    = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_REMU   = 3'b111;

    typedef struct packed {
        logic [FUNCT3_W-1:0] para;
        logic [XLEN-1:0]     rs0;
        logic [XLEN-1:0]     rs1;
        logic [RLEN-1:0]     rd;
    } op_t;
endpackage

// File: rtl/mul_dispatch_if.sv
// Issue, unit and writeback handshake bundle; master is the surrounding pipeline, slave the dispatcher.
interface mul_dispatch_if;
    import mul_dispatch_pkg::*;

    logic                       enq_valid;
    logic                       enq_ready;
    logic [FUNCT3_W-1:0]        enq_para;
    logic [XLEN-1:0]            enq_rs0;
    logic [XLEN-1:0]            enq_rs1;
    logic [RLEN-1:0]            enq_rd;
    logic                       mul_initial;
    logic [FUNCT3_W-1:0]        mul_para;
    logic [XLEN-1:0]            mul_rs0;
    logic [XLEN-1:0]            mul_rs1;
    logic                       mul_ready;
    logic                       mul_finished;
    logic [MULBUF_LEN*XLEN-1:0] mul_data;
    logic                       mul_ack;
    logic                       wb_valid;
    logic [RLEN-1:0]            wb_rd;
    logic [XLEN-1:0]            wb_data;
    logic                       wb_ready;

    modport master (
        output enq_valid, enq_para, enq_rs0, enq_rs1, enq_rd, mul_ready, mul_finished, mul_data, wb_ready,
        input  enq_ready, mul_initial, mul_para, mul_rs0, mul_rs1, mul_ack, wb_valid, wb_rd, wb_data
    );
    modport slave (
        input  enq_valid, enq_para, enq_rs0, enq_rs1, enq_rd, mul_ready, mul_finished, mul_data, wb_ready,
        output enq_ready, mul_initial, mul_para, mul_rs0, mul_rs1, mul_ack, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/mul_dispatch_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; head reads 0 when empty.
module mul_dispatch_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int PW = $clog2(D),
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wptr_q] <= din_i;
    end

    // Gate the head so stale storage never leaks out of an empty queue.
    assign dout_o  = (cnt_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/mul_dispatch.sv
// In-order issue/retire wrapper around the MUL/DIV unit: op queue in front, rd tag queue behind.
// MUL_DISPATCH_BYPASS_EN lets an op offered to an empty queue reach the unit in the same cycle.
module mul_dispatch
    import mul_dispatch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_DEPTH = 4,
    localparam int OP_CW  = $clog2(DEPTH + 1),
    localparam int TAG_CW = $clog2(TAG_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_pipeline,
    mul_dispatch_if.slave     bus,
    output logic [TAG_CW-1:0] pending,
    output logic              tag_err
);
    op_t               enq_op, head_op, issue_op;
    logic [OP_CW-1:0]  op_cnt;
    logic [TAG_CW-1:0] tag_cnt;
    logic [RLEN-1:0]   tag_head;
    logic              op_push, op_pop, issue, tag_space, enq_fire;
    logic              clr_q, tag_err_q, tag_err_d;
    logic              unused_hi;

    assign enq_op    = '{para: bus.enq_para, rs0: bus.enq_rs0, rs1: bus.enq_rs1, rd: bus.enq_rd};
    assign tag_space = tag_cnt != TAG_CW'(TAG_DEPTH);
    assign bus.enq_ready = op_cnt != OP_CW'(DEPTH);
    assign enq_fire  = bus.enq_valid & bus.enq_ready & ~clear_pipeline;

    always_comb begin
        issue_op        = head_op;
        bus.mul_initial = (op_cnt != '0) & tag_space;
`ifdef MUL_DISPATCH_BYPASS_EN
        if (op_cnt == '0 && bus.enq_valid) begin
            issue_op        = enq_op;
            bus.mul_initial = tag_space;
        end
`endif
        issue   = bus.mul_initial & bus.mul_ready & ~clear_pipeline;
        op_pop  = issue & (op_cnt != '0);
        // A bypassed op that issues never occupies a queue slot.
        op_push = enq_fire & ~(issue & (op_cnt == '0));
    end

    assign bus.mul_para = issue_op.para;
    assign bus.mul_rs0  = issue_op.rs0;
    assign bus.mul_rs1  = issue_op.rs1;

    mul_dispatch_fifo #(.W($bits(op_t)), .D(DEPTH)) u_op_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear_pipeline),
        .push_i  (op_push),
        .din_i   (enq_op),
        .pop_i   (op_pop),
        .dout_o  (head_op),
        .count_o (op_cnt)
    );

    assign bus.wb_valid = bus.mul_finished & (tag_cnt != '0);
    assign bus.wb_rd    = tag_head;
    assign bus.wb_data  = bus.mul_data[XLEN-1:0];
    assign bus.mul_ack  = bus.wb_valid & bus.wb_ready & ~clear_pipeline;
    assign unused_hi    = ^bus.mul_data[MULBUF_LEN*XLEN-1:XLEN];

    mul_dispatch_fifo #(.W(RLEN), .D(TAG_DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear_pipeline),
        .push_i  (issue),
        .din_i   (issue_op.rd),
        .pop_i   (bus.mul_ack),
        .dout_o  (tag_head),
        .count_o (tag_cnt)
    );

    // Results straddling a flush are the unit draining, not a tag-tracking fault.
    assign tag_err_d = tag_err_q |
                       (bus.mul_finished & (tag_cnt == '0) & ~clear_pipeline & ~clr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q     <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            clr_q     <= clear_pipeline;
            tag_err_q <= tag_err_d;
        end
    end

    assign pending = tag_cnt;
    assign tag_err = tag_err_q;
endmodule

// File: doc/mul_dispatch.md
Name: mul_dispatch

Overview:
- Issue/retire wrapper directly around the MUL/DIV unit.
- Upstream: accepts MUL/DIV ops from the decode/issue stage into an in-order op queue and presents them to the unit (mul_initial/mul_para/mul_rs0/mul_rs1) when it is ready.
- Downstream: keeps an in-order queue of destination-register tags for in-flight ops and pairs each result word (mul_finished/mul_data) with its rd for the register-file writeback port, generating mul_ack.

Parameters:
- XLEN, 32, operand/result width.
- RLEN, 5, register index width.
- DEPTH, 4, op queue entries (power of 2, ≥2).
- TAG_DEPTH, 4, tag queue entries; must be ≥ MULBUF_LEN+2 (one op computing, one in the unit's write stage, MULBUF_LEN buffered).
- MULBUF_LEN, 2, result words carried on mul_data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enq_valid  in  1  op offered.
- enq_ready  out  1  op queue not full.
- enq_para  in  3  funct3 of the MUL/DIV op.
- enq_rs0  in  XLEN  operand 0.
- enq_rs1  in  XLEN  operand 1.
- enq_rd  in  RLEN  destination register.
- mul_initial  out  1  head op valid toward the unit.
- mul_para  out  3  head funct3.
- mul_rs0  out  XLEN  head operand 0.
- mul_rs1  out  XLEN  head operand 1.
- mul_ready  in  1  unit idle.
- mul_finished  in  1  unit has ≥1 result word.
- mul_data  in  MULBUF_LEN*XLEN  result words, oldest in [XLEN-1:0].
- mul_ack  out  1  oldest result word consumed.
- wb_valid  out  1  writeback request.
- wb_rd  out  RLEN  writeback register.
- wb_data  out  XLEN  writeback value.
- wb_ready  in  1  register-file port granted.
- clear_pipeline  in  1  flush (branch mispredict/trap).
- pending  out  $clog2(TAG_DEPTH+1)  issued-but-unretired op count.
- tag_err  out  1  sticky: result arrived with tag queue empty.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - both queues empty, pending=0, tag_err=0.
  - After reset: enq_ready=1; mul_initial=0, mul_ack=0, wb_valid=0.
  - mul_para/mul_rs0/mul_rs1/wb_rd read 0 while their queue is empty.
- Enqueue:
  - enq fires = enq_valid & enq_ready & ~clear_pipeline.
  - enq_ready = op_count<DEPTH, from registered count only. No enqueue when full, even if an issue occurs in the same cycle.
  - Entry becomes visible at the queue head the next cycle (1-cycle latency, enq to mul_initial).
- Issue:
  - mul_initial = op_count!=0 & tag_count<TAG_DEPTH.
  - issue fires = mul_initial & mul_ready & ~clear_pipeline. On issue: pop op queue; push enq_rd of that op into the tag queue.
  - mul_initial may stay high across cycles while mul_ready=0; head fields must stay stable until issue.
- Retire:
  - wb_valid = mul_finished & tag_count!=0.
  - wb_data = mul_data[XLEN-1:0]; wb_rd = tag head.
  - mul_ack = wb_valid & wb_ready. On mul_ack the tag queue pops.
  - Ops with rd=0 are issued and retired normally; suppression is left to the register file.
- Simultaneous events:
  - A tag push (issue) and tag pop (ack) in one cycle leave tag_count unchanged.
  - Enq and issue in one cycle leave op_count unchanged.
- pending = tag_count (registered).
- tag_err:
  - Set when mul_finished=1 and tag_count=0, with no clear_pipeline in that cycle or the previous one.
  - Cleared only by rst.
  - mul_ack stays 0 in that case.
- clear_pipeline:
  - Same cycle: no enq, no issue, and mul_ack forced 0.
  - Next edge: both queues emptied (pointers and counts to 0).
  - The unit flushes itself on the same signal; this block retains nothing.
- Pointer arithmetic: pointers are $clog2(depth) bits and wrap modulo depth; full/empty come from separate counts, not pointer compare.

Optional Feature:
- Macro MUL_DISPATCH_BYPASS_EN.
- Defined: when the op queue is empty and enq_valid=1, the enq_* fields drive mul_para/mul_rs0/mul_rs1 combinationally and mul_initial = enq_valid & tag_count<TAG_DEPTH.
  - If the issue fires, the op is not written into the op queue (0-cycle latency) and enq_rd is pushed to the tag queue.
  - If the issue does not fire, the op is enqueued normally.
- Undefined: 1-cycle latency as above; no enq-to-mul combinational path.

Decomposition:
- Shared package/define file: XLEN, MULBUF_LEN, RLEN, the funct3 width (3), and the MUL/DIV funct3 encodings.
- One natural sub-module, mul_dispatch_fifo: a synchronous FIFO parameterised by width and depth, with count output and synchronous flush. It is instantiated twice: op queue width 3+2*XLEN+RLEN, tag queue width RLEN.

Test Plan:
- Reset then idle → enq_ready=1, mul_initial=0, wb_valid=0, pending=0, tag_err=0.
- Single op: enq para=0, rs0=3, rs1=5, rd=7, mul_ready=1 → mul_initial next cycle with the same fields. Then drive mul_finished=1, mul_data[31:0]=15, wb_ready=1 → wb_rd=7, wb_data=15, mul_ack=1, pending back to 0.
- Back-pressure: mul_ready=0, enqueue 5 ops → enq_ready drops after 4 and the 5th is held. Release mul_ready → ops issue in order; wb_rd sequence matches enq_rd order (1,2,3,4).
- Tag-full stall: wb_ready=0 with TAG_DEPTH ops issued → mul_initial=0 despite a queued op. wb_ready=1 for one cycle → one ack, then issue resumes.
- Flush: 3 queued + 2 in flight, pulse clear_pipeline → next cycle pending=0, enq_ready=1, mul_initial=0. Same-cycle enq_valid is dropped; tag_err stays 0.
- Spurious result: tag queue empty, mul_finished=1 → wb_valid=0, mul_ack=0, tag_err=1 latched until rst. With MUL_DISPATCH_BYPASS_EN, an empty-queue enq with mul_ready=1 gives mul_initial=1 in the same cycle.
